alu_share_ctrl: RTL
===================

Name: alu_share_ctrl

Overview:
- Shares one ALU instance between NREQ requesters: round-robin arbitration, operand capture, ALU sequencing with command-dependent latency, result return tagged with the requester index.
- Sits between requester agents (or upstream blocks) and the ALU's input/output port groups.
- One operation in flight at a time (non-pipelined).

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, ALU operand width.
- CWIDTH, 3, ALU command field msb index; cmd is CWIDTH+1 bits.
- ALU_LAT, 1, result latency in cycles for ordinary commands.
- MUL_LAT, 2, result latency for multiply commands (mode=1, cmd 9 or 10).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request, held until granted.
- req_inp_valid  input  2*NREQ  per-requester operand-valid pair.
- req_mode  input  NREQ  per-requester mode (1=arith, 0=logic).
- req_cmd  input  NREQ*(CWIDTH+1)  per-requester command.
- req_opa, req_opb  input  NREQ*WIDTH each  per-requester operands.
- req_cin  input  NREQ  per-requester carry-in.
- gnt  output  NREQ  one-hot grant pulse; operands captured that cycle.
- alu_ce, alu_cin, alu_mode  output  1 each  ALU controls.
- alu_inp_valid  output  2;  alu_cmd  output  CWIDTH+1;  alu_opa, alu_opb  output  WIDTH each.
- alu_res  input  WIDTH+1;  alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e  input  1 each.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_id  output  clog2(NREQ)  index of the served requester.
- rsp_res  output  WIDTH+1;  rsp_err  output 1;  rsp_flags  output 5  {oflow,cout,g,l,e}.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE, rr pointer=0, all outputs 0, latched operands 0. Reset mid-operation aborts; no rsp_valid is ever produced for the aborted op.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; also IDLE -> REJECT -> IDLE.
- IDLE: if req!=0, winner = first set bit at or after rr pointer (wrapping). gnt[winner]=1 for exactly this cycle; latch the winner's fields and id. Latched inp_valid==2'b00 -> REJECT, else -> ISSUE. If req==0, stay, gnt=0.
- ISSUE (1 cycle): alu_ce=1, alu_* driven from latch. L = MUL_LAT if mode=1 and cmd in {9,10}, else ALU_LAT; load counter=L.
- WAIT (L cycles): alu_ce=1, alu_* held stable; decrement counter; on the last WAIT cycle, capture alu_res/err/flags into rsp registers at the clock edge.
- RESP (1 cycle): rsp_valid=1 with captured values; rr pointer = winner+1 mod NREQ; alu_ce=0.
- REJECT (1 cycle): rsp_valid=1, rsp_err=1, rsp_res=0, rsp_flags=0; pointer advances as in RESP; ALU untouched.
- Timing: gnt in cycle N -> rsp_valid in cycle N+2+L (N+1 for REJECT).
- alu_ce=0 in IDLE, RESP, REJECT; alu_* operand outputs hold last value.
- Requests arriving while busy are ignored (no gnt) until IDLE. Requester may drop req before gnt without effect. rsp_* hold their values between pulses.
- Fairness: continuously asserted req bit is granted within NREQ operations.

Decomposition:
- Package alu_ctrl_pkg: state enum, MUL command constants (9, 10), flag-vector bit positions, latency-select function.
- Sub-module rr_arbiter (req vector + pointer -> one-hot winner and index, purely combinational); pointer register stays in alu_share_ctrl.

Test Plan:
- Single request: req=4'b0001, mode=1, cmd=0 (ADD), opa=8'h05, opb=8'h03, inp_valid=11, ALU_LAT=1 -> gnt=0001 cycle N, alu_ce high N+1..N+2, rsp_valid at N+3, rsp_id=0, rsp_res=9'h008.
- Multiply latency: requester 2, mode=1, cmd=9, opa=3, opb=4 -> rsp_valid at N+4 (MUL_LAT=2), rsp_id=2, alu_* operands stable throughout ISSUE+WAIT.
- Round robin: req=4'b1111 held for 8 ops -> grant order 0,1,2,3,0,1,2,3; never two gnt bits set.
- Reject: inp_valid=00 from requester 1 -> rsp_valid one cycle after gnt, rsp_err=1, rsp_res=0, alu_ce stays 0.
- Reset mid-op: rst=0 during WAIT -> all outputs 0 immediately; after release, no rsp_valid until a new gnt; pointer restarts at requester 0.
- Busy ignore: requester 3 asserts req one cycle after requester 0 is granted -> no gnt until RESP completes, then gnt=1000 in the next IDLE cycle.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and helpers for the ALU sharing controller.
//   state_t   : controller FSM states
//   CMD_MUL_* : command codes that select the multiply latency (arith mode only)
//   FLG_*     : bit positions inside the 5-bit response flag vector
//   lat_sel   : result latency for a given mode/command
package alu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_RESP   = 3'd3,
      ST_REJECT = 3'd4
   } state_t;

   localparam int unsigned CMD_MUL_A = 9;
   localparam int unsigned CMD_MUL_B = 10;

   localparam int unsigned FLG_W     = 5;
   localparam int unsigned FLG_OFLOW = 4;
   localparam int unsigned FLG_COUT  = 3;
   localparam int unsigned FLG_G     = 2;
   localparam int unsigned FLG_L     = 1;
   localparam int unsigned FLG_E     = 0;

   // Multiply commands only exist in arithmetic mode; everything else uses the ordinary latency.
   function automatic int unsigned lat_sel(input logic        mode,
                                           input int unsigned cmd,
                                           input int unsigned alu_lat,
                                           input int unsigned mul_lat);
      if (mode && (cmd == CMD_MUL_A || cmd == CMD_MUL_B)) begin
         return mul_lat;
      end
      return alu_lat;
   endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or after ptr, wrapping.
//   req       : request vector
//   ptr       : search start index
//   win_oh_c  : one-hot winner (zero when no request)
//   win_idx_c : winner index (zero when no request)
//   win_any_c : at least one request present
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]          req,
   input  logic [$clog2(N)-1:0]  ptr,
   output logic [N-1:0]          win_oh_c,
   output logic [$clog2(N)-1:0]  win_idx_c,
   output logic                  win_any_c
);

   localparam int unsigned IDW = $clog2(N);

   // Scan N positions starting at ptr; the first hit wins.
   always_comb begin : p_pick
      int unsigned j;
      win_oh_c  = '0;
      win_idx_c = '0;
      win_any_c = 1'b0;
      j         = 0;
      for (int unsigned i = 0; i < N; i++) begin
         j = 32'(ptr) + i;
         if (j >= N) begin
            j = j - N;
         end
         if (!win_any_c && req[j]) begin
            win_any_c   = 1'b1;
            win_oh_c[j] = 1'b1;
            win_idx_c   = IDW'(j);
         end
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one non-pipelined ALU between NREQ requesters with round-robin arbitration.
//   clk, rst            : clock, asynchronous active-low reset
//   req / req_*         : per-requester request and packed operand/command fields
//   gnt                 : one-hot grant, asserted in the IDLE cycle the fields are captured
//   alu_*  (outputs)    : ALU enable and operands, held stable while alu_ce is high
//   alu_*  (inputs)     : ALU result and status
//   rsp_*               : one-cycle response pulse tagged with the served requester
//   busy                : controller not in IDLE
module alu_share_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned CWIDTH  = 3,
   parameter int unsigned ALU_LAT = 1,
   parameter int unsigned MUL_LAT = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NREQ-1:0]             req,
   input  logic [2*NREQ-1:0]           req_inp_valid,
   input  logic [NREQ-1:0]             req_mode,
   input  logic [NREQ*(CWIDTH+1)-1:0]  req_cmd,
   input  logic [NREQ*WIDTH-1:0]       req_opa,
   input  logic [NREQ*WIDTH-1:0]       req_opb,
   input  logic [NREQ-1:0]             req_cin,
   output logic [NREQ-1:0]             gnt,
   output logic                        alu_ce,
   output logic                        alu_cin,
   output logic                        alu_mode,
   output logic [1:0]                  alu_inp_valid,
   output logic [CWIDTH:0]             alu_cmd,
   output logic [WIDTH-1:0]            alu_opa,
   output logic [WIDTH-1:0]            alu_opb,
   input  logic [WIDTH:0]              alu_res,
   input  logic                        alu_err,
   input  logic                        alu_oflow,
   input  logic                        alu_cout,
   input  logic                        alu_g,
   input  logic                        alu_l,
   input  logic                        alu_e,
   output logic                        rsp_valid,
   output logic [$clog2(NREQ)-1:0]     rsp_id,
   output logic [WIDTH:0]              rsp_res,
   output logic                        rsp_err,
   output logic [4:0]                  rsp_flags,
   output logic                        busy
);

   localparam int unsigned IDW     = $clog2(NREQ);
   localparam int unsigned CW      = CWIDTH + 1;
   localparam int unsigned LAT_MAX = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
   localparam int unsigned CNTW    = $clog2(LAT_MAX + 1);

   state_t            state;
   state_t            state_d;
   logic [IDW-1:0]    rr_ptr;
   logic [IDW-1:0]    lat_id;
   logic [CNTW-1:0]   cnt;
   logic [NREQ-1:0]   win_oh;
   logic [IDW-1:0]    win_idx;
   logic              win_any;
   logic [1:0]        win_iv;
   logic              last_wait;
   logic [FLG_W-1:0]  flags_c;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req       (req),
      .ptr       (rr_ptr),
      .win_oh_c  (win_oh),
      .win_idx_c (win_idx),
      .win_any_c (win_any)
   );

   assign win_iv    = req_inp_valid[2*win_idx +: 2];
   assign last_wait = (state == ST_WAIT) && (cnt == CNTW'(1));

   // Grant is a same-cycle decision in IDLE; forced low while reset is held.
   always_comb begin
      gnt = '0;
      if (state == ST_IDLE && rst) begin
         gnt = win_oh;
      end
   end

   // Pack ALU status into the response flag vector.
   always_comb begin
      flags_c            = '0;
      flags_c[FLG_OFLOW] = alu_oflow;
      flags_c[FLG_COUT]  = alu_cout;
      flags_c[FLG_G]     = alu_g;
      flags_c[FLG_L]     = alu_l;
      flags_c[FLG_E]     = alu_e;
   end

   // Next-state logic.
   always_comb begin
      state_d = state;
      case (state)
         ST_IDLE: begin
            if (win_any) begin
               state_d = (win_iv == 2'b00) ? ST_REJECT : ST_ISSUE;
            end
         end
         ST_ISSUE:  state_d = ST_WAIT;
         ST_WAIT: begin
            if (last_wait) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP:   state_d = ST_IDLE;
         ST_REJECT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // State register, operand latch, latency counter and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= ST_IDLE;
         rr_ptr        <= '0;
         lat_id        <= '0;
         cnt           <= '0;
         busy          <= 1'b0;
         alu_ce        <= 1'b0;
         alu_cin       <= 1'b0;
         alu_mode      <= 1'b0;
         alu_inp_valid <= '0;
         alu_cmd       <= '0;
         alu_opa       <= '0;
         alu_opb       <= '0;
         rsp_valid     <= 1'b0;
         rsp_id        <= '0;
         rsp_res       <= '0;
         rsp_err       <= 1'b0;
         rsp_flags     <= '0;
      end else begin
         state     <= state_d;
         busy      <= (state_d != ST_IDLE);
         alu_ce    <= (state_d == ST_ISSUE) || (state_d == ST_WAIT);
         rsp_valid <= (state_d == ST_RESP) || (state_d == ST_REJECT);
         case (state)
            ST_IDLE: begin
               if (win_any) begin
                  lat_id <= win_idx;
                  if (win_iv == 2'b00) begin
                     // Rejected ops never reach the ALU, so its port group is left as-is.
                     rsp_id    <= win_idx;
                     rsp_err   <= 1'b1;
                     rsp_res   <= '0;
                     rsp_flags <= '0;
                  end else begin
                     alu_mode      <= req_mode[win_idx];
                     alu_cin       <= req_cin[win_idx];
                     alu_inp_valid <= win_iv;
                     alu_cmd       <= req_cmd[CW*win_idx +: CW];
                     alu_opa       <= req_opa[WIDTH*win_idx +: WIDTH];
                     alu_opb       <= req_opb[WIDTH*win_idx +: WIDTH];
                  end
               end
            end
            ST_ISSUE: begin
               cnt <= CNTW'(lat_sel(alu_mode, 32'(alu_cmd), ALU_LAT, MUL_LAT));
            end
            ST_WAIT: begin
               cnt <= cnt - CNTW'(1);
               if (last_wait) begin
                  rsp_id    <= lat_id;
                  rsp_res   <= alu_res;
                  rsp_err   <= alu_err;
                  rsp_flags <= flags_c;
               end
            end
            ST_RESP, ST_REJECT: begin
               rr_ptr <= (lat_id == IDW'(NREQ - 1)) ? '0 : lat_id + IDW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
